multicycle_ctrl_fsm: RTL and testbench



---
 rtl/rv_ctrl_pkg.sv | 67 ++++++
 rtl/ctrl_out_decode.sv | 90 +++++++++
 rtl/multicycle_ctrl_fsm.sv | 91 +++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared constants and control-vector type for the multicycle RV32I control sequencer.
package rv_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_RDATA  = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;
  } ctrl_t;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) || (op == OP_I) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational decode of FSM state (plus op/zero/mem_ready) into the datapath control vector.
module ctrl_out_decode
  import rv_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_B;
        ctrl.illegal   = !op_legal(op);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        ctrl.imm_src    = IMM_J;
      end
      S_LUI: begin
        // A operand is zero-selected by the datapath for LUI.
        ctrl.imm_src    = IMM_U;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.reg_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I main control sequencer: state register, next-state logic and output gating.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned IMM_W = 3,
  parameter int unsigned OP_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [IMM_W-1:0] imm_src,
  output logic             illegal,
  output logic [3:0]       state_dbg
);

  logic [3:0] state_q, state_d;
  logic [6:0] op7;
  ctrl_t      ctrl;

  assign op7 = 7'(op);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op7)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op7 == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  ctrl_out_decode u_decode (
    .state     (state_q),
    .op        (op7),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Strobes are forced low while reset is held so an aborted access drops immediately.
  assign mem_req    = ctrl.mem_req   & rst_n;
  assign mem_write  = ctrl.mem_write & rst_n;
  assign ir_write   = ctrl.ir_write  & rst_n;
  assign pc_write   = ctrl.pc_write  & rst_n;
  assign reg_write  = ctrl.reg_write & rst_n;
  assign illegal    = ctrl.illegal   & rst_n;
  assign adr_src    = ctrl.adr_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign imm_src    = IMM_W'(ctrl.imm_src);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm with a per-cycle expected-vector scoreboard.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic [3:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.IMM_W(3), .OP_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .imm_src    (imm_src),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
  );

  // Vector layout: state | {req,wr,adr,ir,pc,rw,ill} | a | b | aluop | res | imm
  function automatic logic [21:0] mk(input logic [3:0] st, input logic [6:0] strb,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] aop, input logic [1:0] rs,
                                     input logic [2:0] imm);
    return {st, strb, a, b, aop, rs, imm};
  endfunction

  // Monitor: every output cycle that has a pending expectation is checked at the falling edge.
  always @(negedge clk) begin
    logic [21:0] act, exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act = {state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal,
             alu_src_a, alu_src_b, alu_op, result_src, imm_src};
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL vec%0d @%0t: got st=%0d strb=%b a=%0d b=%0d op=%0d res=%0d imm=%0d, want st=%0d strb=%b a=%0d b=%0d op=%0d res=%0d imm=%0d",
                 vectors, $time, act[21:18], act[17:11], act[10:9], act[8:7], act[6:5],
                 act[4:3], act[2:0], exp_v[21:18], exp_v[17:11], exp_v[10:9], exp_v[8:7],
                 exp_v[6:5], exp_v[4:3], exp_v[2:0]);
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge and queue its expected outputs.
  task automatic step(input logic [6:0] o, input logic z, input logic rdy, input logic [21:0] e);
    op = o;
    zero = z;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [21:0] v_rst, v_fstall, v_fgo, v_dec, v_decill, v_adr_ld, v_adr_st, v_mrd, v_mwb,
               v_mwr, v_exr, v_exi, v_awb, v_beq1, v_beq0, v_jal, v_lui;

  initial begin
    v_rst    = mk(4'd0,  7'b0000000, 2'd0, 2'd2, 2'd0, 2'd2, 3'd0);
    v_fstall = mk(4'd0,  7'b1000000, 2'd0, 2'd2, 2'd0, 2'd2, 3'd0);
    v_fgo    = mk(4'd0,  7'b1001100, 2'd0, 2'd2, 2'd0, 2'd2, 3'd0);
    v_dec    = mk(4'd1,  7'b0000000, 2'd1, 2'd1, 2'd0, 2'd0, 3'd2);
    v_decill = mk(4'd1,  7'b0000001, 2'd1, 2'd1, 2'd0, 2'd0, 3'd2);
    v_adr_ld = mk(4'd2,  7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 3'd0);
    v_adr_st = mk(4'd2,  7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 3'd1);
    v_mrd    = mk(4'd3,  7'b1010000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    v_mwb    = mk(4'd4,  7'b0000010, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0);
    v_mwr    = mk(4'd5,  7'b1110000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    v_exr    = mk(4'd6,  7'b0000000, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0);
    v_exi    = mk(4'd7,  7'b0000000, 2'd2, 2'd1, 2'd2, 2'd0, 3'd0);
    v_awb    = mk(4'd8,  7'b0000010, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    v_beq1   = mk(4'd9,  7'b0000100, 2'd2, 2'd0, 2'd1, 2'd0, 3'd0);
    v_beq0   = mk(4'd9,  7'b0000000, 2'd2, 2'd0, 2'd1, 2'd0, 3'd0);
    v_jal    = mk(4'd10, 7'b0000100, 2'd1, 2'd2, 2'd0, 2'd0, 3'd3);
    v_lui    = mk(4'd11, 7'b0000010, 2'd0, 2'd1, 2'd0, 2'd2, 3'd4);

    // Held in reset with mem_ready high: FETCH selects, every strobe low.
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(v_rst);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load with a three-cycle read stall.
    step(7'b0000011, 1'b0, 1'b1, v_fgo);
    step(7'b0000011, 1'b0, 1'b0, v_dec);
    step(7'b0000011, 1'b0, 1'b1, v_adr_ld);
    step(7'b0000011, 1'b0, 1'b0, v_mrd);
    step(7'b0000011, 1'b0, 1'b0, v_mrd);
    step(7'b0000011, 1'b0, 1'b0, v_mrd);
    step(7'b0000011, 1'b0, 1'b1, v_mrd);
    step(7'b0000011, 1'b0, 1'b0, v_mwb);

    // Store with one fetch stall and one write stall.
    step(7'b0100011, 1'b0, 1'b0, v_fstall);
    step(7'b0100011, 1'b0, 1'b1, v_fgo);
    step(7'b0100011, 1'b0, 1'b0, v_dec);
    step(7'b0100011, 1'b0, 1'b0, v_adr_st);
    step(7'b0100011, 1'b0, 1'b0, v_mwr);
    step(7'b0100011, 1'b0, 1'b1, v_mwr);

    // R-type with mem_ready held high where it must be ignored.
    step(7'b0110011, 1'b0, 1'b1, v_fgo);
    step(7'b0110011, 1'b0, 1'b1, v_dec);
    step(7'b0110011, 1'b0, 1'b1, v_exr);
    step(7'b0110011, 1'b0, 1'b1, v_awb);

    // I-type ALU.
    step(7'b0010011, 1'b0, 1'b1, v_fgo);
    step(7'b0010011, 1'b0, 1'b0, v_dec);
    step(7'b0010011, 1'b0, 1'b0, v_exi);
    step(7'b0010011, 1'b0, 1'b0, v_awb);

    // Branch taken, then not taken.
    step(7'b1100011, 1'b1, 1'b1, v_fgo);
    step(7'b1100011, 1'b1, 1'b0, v_dec);
    step(7'b1100011, 1'b1, 1'b0, v_beq1);
    step(7'b1100011, 1'b0, 1'b1, v_fgo);
    step(7'b1100011, 1'b0, 1'b0, v_dec);
    step(7'b1100011, 1'b0, 1'b0, v_beq0);

    // JAL then LUI.
    step(7'b1101111, 1'b0, 1'b1, v_fgo);
    step(7'b1101111, 1'b0, 1'b0, v_dec);
    step(7'b1101111, 1'b0, 1'b0, v_jal);
    step(7'b1101111, 1'b0, 1'b0, v_awb);
    step(7'b0110111, 1'b0, 1'b1, v_fgo);
    step(7'b0110111, 1'b0, 1'b0, v_dec);
    step(7'b0110111, 1'b0, 1'b0, v_lui);

    // Unsupported opcode: single illegal pulse, then back to FETCH.
    step(7'b1111111, 1'b0, 1'b1, v_fgo);
    step(7'b1111111, 1'b0, 1'b0, v_decill);
    step(7'b1111111, 1'b0, 1'b0, v_fstall);

    // Store aborted by reset mid write-stall.
    step(7'b0100011, 1'b0, 1'b1, v_fgo);
    step(7'b0100011, 1'b0, 1'b0, v_dec);
    step(7'b0100011, 1'b0, 1'b0, v_adr_st);
    step(7'b0100011, 1'b0, 1'b0, v_mwr);
    mem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_q.push_back(v_rst);
    @(posedge clk);
    #1;
    exp_q.push_back(v_rst);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(7'b0000000, 1'b0, 1'b0, v_fstall);
    step(7'b0000000, 1'b0, 1'b1, v_fgo);

    // Every queued expectation must have been consumed by the monitor.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
